// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_unit
// Description : Multi-cycle HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU,
//               MTHI/MTLO) with a countdown busy interlock.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        MnDStart,
   input  logic [1:0]  MnDOp,
   input  logic        MnDWe,
   input  logic        MnDWeSel,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        MnDBusy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam logic [3:0] MULT_CYCLES    = 4'd5;
   localparam logic [3:0] DIV_CYCLES     = 4'd10;
   localparam logic [3:0] MULT_LAST_STEP = 4'd2;
   localparam logic [3:0] DIV_LAST_STEP  = 4'd3;
   localparam logic [3:0] DONE_COUNT     = 4'd1;

   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [63:0] acc_q, acc_d;
   logic        is_div_q, is_div_d;
   logic        neg_lo_q, neg_lo_d;
   logic        neg_hi_q, neg_hi_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        busy;
   logic        op_signed;
   logic        op_div;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [39:0] pp;
   logic [63:0] div_next;
   logic [63:0] prod_fix;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;

   // One restoring-division step on {remainder, dividend/quotient}.
   function automatic logic [63:0] div_step(input logic [63:0] acc, input logic [31:0] dvs);
      logic [32:0] rs;
      logic [32:0] diff;
      rs   = {acc[63:32], acc[31]};
      diff = rs - {1'b0, dvs};
      if (!diff[32]) begin
         return {diff[31:0], acc[30:0], 1'b1};
      end
      return {rs[31:0], acc[30:0], 1'b0};
   endfunction

   assign busy      = (cnt_q != 4'd0);
   assign op_signed = ~MnDOp[0];
   assign op_div    = MnDOp[1];
   assign a_neg     = op_signed & A[31];
   assign b_neg     = op_signed & B[31];
   assign a_mag     = a_neg ? (32'd0 - A) : A;
   assign b_mag     = b_neg ? (32'd0 - B) : B;

   // Multiplier consumes one multiplier byte per cycle, MSB first (Horner form).
   assign pp        = 40'(a_q) * 40'(b_q[31:24]);
   assign div_next  = div_step(div_step(div_step(div_step(acc_q, b_q), b_q), b_q), b_q);

   assign prod_fix  = neg_lo_q ? (64'd0 - acc_q) : acc_q;
   assign quo_fix   = neg_lo_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
   assign rem_fix   = neg_hi_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

   always_comb begin
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      is_div_d = is_div_q;
      neg_lo_d = neg_lo_q;
      neg_hi_d = neg_hi_q;
      hi_d     = hi_q;
      lo_d     = lo_q;

      if (busy) begin
         cnt_d = cnt_q - 4'd1;
         if (is_div_q) begin
            if (cnt_q >= DIV_LAST_STEP) begin
               acc_d = div_next;
            end
         end else if (cnt_q >= MULT_LAST_STEP) begin
            acc_d = {acc_q[55:0], 8'h00} + {24'h000000, pp};
            b_d   = {b_q[23:0], 8'h00};
         end

         if (cnt_q == DONE_COUNT) begin
            if (is_div_q) begin
               // A zero divisor completes silently, leaving HI/LO intact.
               if (b_q != 32'd0) begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end
            end else begin
               hi_d = prod_fix[63:32];
               lo_d = prod_fix[31:0];
            end
         end
      end else if (MnDStart) begin
         cnt_d    = op_div ? DIV_CYCLES : MULT_CYCLES;
         a_d      = a_mag;
         b_d      = b_mag;
         is_div_d = op_div;
         acc_d    = op_div ? {32'd0, a_mag} : 64'd0;
         neg_lo_d = a_neg ^ b_neg;
         // Remainder follows the dividend's sign; product sign covers both halves.
         neg_hi_d = op_div ? a_neg : (a_neg ^ b_neg);
      end else if (MnDWe) begin
         if (MnDWeSel) begin
            hi_d = A;
         end else begin
            lo_d = A;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= 4'd0;
         a_q      <= 32'd0;
         b_q      <= 32'd0;
         acc_q    <= 64'd0;
         is_div_q <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
      end else begin
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         is_div_q <= is_div_d;
         neg_lo_q <= neg_lo_d;
         neg_hi_q <= neg_hi_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign MnDBusy = busy;
   assign HI      = hi_q;
   assign LO      = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Directed self-checking bench for mul_div_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   logic        clk = 1'b0;
   logic        reset;
   logic        MnDStart;
   logic [1:0]  MnDOp;
   logic        MnDWe;
   logic        MnDWeSel;
   logic [31:0] A;
   logic [31:0] B;
   logic        MnDBusy;
   logic [31:0] HI;
   logic [31:0] LO;

   int checks = 0;
   int errors = 0;

   mul_div_unit dut (
      .clk      (clk),
      .reset    (reset),
      .MnDStart (MnDStart),
      .MnDOp    (MnDOp),
      .MnDWe    (MnDWe),
      .MnDWeSel (MnDWeSel),
      .A        (A),
      .B        (B),
      .MnDBusy  (MnDBusy),
      .HI       (HI),
      .LO       (LO)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      MnDOp    = op;
      A        = a;
      B        = b;
      MnDStart = 1'b1;
      tick();
      MnDStart = 1'b0;
      A        = 32'hA5A5_5A5A;
      B        = 32'h3C3C_C3C3;
   endtask

   task automatic wait_busy(output int n);
      n = 0;
      while (MnDBusy === 1'b1 && n < 40) begin
         n++;
         tick();
      end
   endtask

   task automatic write_hilo(input logic sel, input logic [31:0] val);
      MnDWe    = 1'b1;
      MnDWeSel = sel;
      A        = val;
      tick();
      MnDWe    = 1'b0;
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      MnDStart = 1'b0;
      MnDWe    = 1'b0;
      MnDWeSel = 1'b0;
      MnDOp    = 2'b00;
      A        = 32'd0;
      B        = 32'd0;
      tick();
      tick();
      reset = 1'b0;
      checks++; if (MnDBusy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", MnDBusy); end
      checks++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected 00000000", HI); end
      checks++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected 00000000", LO); end
   endtask

   task automatic test_mult();
      int n;
      issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
      checks++; if (HI !== 32'd0 || LO !== 32'd0) begin errors++; $display("FAIL mult_hold: got %h_%h expected 00000000_00000000", HI, LO); end
      wait_busy(n);
      checks++; if (n != 5) begin errors++; $display("FAIL mult_busy_cycles: got %0d expected 5", n); end
      checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h expected ffffffff", HI); end
      checks++; if (LO !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo: got %h expected fffffffa", LO); end
   endtask

   task automatic test_multu();
      int n;
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_busy(n);
      checks++; if (n != 5) begin errors++; $display("FAIL multu_busy_cycles: got %0d expected 5", n); end
      checks++; if (HI !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h expected fffffffe", HI); end
      checks++; if (LO !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h expected 00000001", LO); end
   endtask

   task automatic test_div();
      int n;
      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
      wait_busy(n);
      checks++; if (n != 10) begin errors++; $display("FAIL div_busy_cycles: got %0d expected 10", n); end
      checks++; if (LO !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h expected fffffffd", LO); end
      checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h expected ffffffff", HI); end
      issue(OP_DIVU, 32'd7, 32'd0);
      wait_busy(n);
      checks++; if (n != 10) begin errors++; $display("FAIL div0_busy_cycles: got %0d expected 10", n); end
      checks++; if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div0_unchanged: got %h_%h expected ffffffff_fffffffd", HI, LO); end
   endtask

   task automatic test_div_signs();
      int n;
      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_busy(n);
      checks++; if (LO !== 32'h8000_0000 || HI !== 32'h0000_0000) begin errors++; $display("FAIL div_overflow: got %h_%h expected 00000000_80000000", HI, LO); end
      issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
      wait_busy(n);
      checks++; if (LO !== 32'hFFFF_FFFD || HI !== 32'h0000_0001) begin errors++; $display("FAIL div_neg_divisor: got %h_%h expected 00000001_fffffffd", HI, LO); end
      issue(OP_DIVU, 32'd100, 32'd7);
      wait_busy(n);
      checks++; if (LO !== 32'd14 || HI !== 32'd2) begin errors++; $display("FAIL divu_basic: got %h_%h expected 00000002_0000000e", HI, LO); end
   endtask

   task automatic test_mthi_mtlo();
      int m;
      write_hilo(1'b1, 32'h1234_5678);
      checks++; if (HI !== 32'h1234_5678) begin errors++; $display("FAIL mthi_hi: got %h expected 12345678", HI); end
      checks++; if (LO !== 32'd14) begin errors++; $display("FAIL mthi_lo_kept: got %h expected 0000000e", LO); end
      write_hilo(1'b0, 32'hCAFE_F00D);
      checks++; if (LO !== 32'hCAFE_F00D || HI !== 32'h1234_5678) begin errors++; $display("FAIL mtlo: got %h_%h expected 12345678_cafef00d", HI, LO); end
      issue(OP_MULT, 32'd3, 32'd4);
      MnDWe    = 1'b1;
      MnDWeSel = 1'b1;
      MnDStart = 1'b1;
      MnDOp    = OP_DIV;
      A        = 32'hDEAD_BEEF;
      B        = 32'd1;
      tick();
      MnDWe    = 1'b0;
      MnDStart = 1'b0;
      checks++; if (HI !== 32'h1234_5678) begin errors++; $display("FAIL mthi_busy_ignored: got %h expected 12345678", HI); end
      wait_busy(m);
      checks++; if (m + 1 != 5) begin errors++; $display("FAIL start_busy_ignored: got %0d busy cycles expected 5", m + 1); end
      checks++; if (HI !== 32'd0 || LO !== 32'd12) begin errors++; $display("FAIL mult_after_ignored: got %h_%h expected 00000000_0000000c", HI, LO); end
   endtask

   task automatic test_start_priority();
      int n;
      MnDWe    = 1'b1;
      MnDWeSel = 1'b1;
      issue(OP_MULT, 32'd5, 32'd6);
      MnDWe    = 1'b0;
      checks++; if (HI !== 32'd0) begin errors++; $display("FAIL start_over_we: got %h expected 00000000", HI); end
      wait_busy(n);
      checks++; if (HI !== 32'd0 || LO !== 32'd30) begin errors++; $display("FAIL start_over_we_result: got %h_%h expected 00000000_0000001e", HI, LO); end
   endtask

   task automatic test_reset_mid_op();
      int n;
      write_hilo(1'b1, 32'h55AA_55AA);
      issue(OP_DIV, 32'd100, 32'd7);
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (MnDBusy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b expected 0", MnDBusy); end
      checks++; if (HI !== 32'd0 || LO !== 32'd0) begin errors++; $display("FAIL reset_mid_hilo: got %h_%h expected 00000000_00000000", HI, LO); end
      issue(OP_MULT, 32'hFFFF_FFF9, 32'd6);
      wait_busy(n);
      checks++; if (n != 5) begin errors++; $display("FAIL post_reset_busy: got %0d expected 5", n); end
      checks++; if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFD6) begin errors++; $display("FAIL post_reset_mult: got %h_%h expected ffffffff_ffffffd6", HI, LO); end
   endtask

   task automatic test_back_to_back();
      int n;
      issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
      wait_busy(n);
      checks++; if (n != 5) begin errors++; $display("FAIL b2b_mult_busy: got %0d expected 5", n); end
      checks++; if (HI !== 32'd1 || LO !== 32'd0) begin errors++; $display("FAIL b2b_mult_result: got %h_%h expected 00000001_00000000", HI, LO); end
      issue(OP_DIVU, 32'hFFFF_FFFF, 32'h10);
      checks++; if (MnDBusy !== 1'b1) begin errors++; $display("FAIL b2b_div_accepted: got %b expected 1", MnDBusy); end
      wait_busy(n);
      checks++; if (n != 10) begin errors++; $display("FAIL b2b_div_busy: got %0d expected 10", n); end
      checks++; if (HI !== 32'hF || LO !== 32'h0FFF_FFFF) begin errors++; $display("FAIL b2b_div_result: got %h_%h expected 0000000f_0fffffff", HI, LO); end
   endtask

   task automatic test_reset_priority();
      reset    = 1'b1;
      MnDStart = 1'b1;
      MnDOp    = OP_DIV;
      MnDWe    = 1'b1;
      MnDWeSel = 1'b0;
      A        = 32'h777;
      B        = 32'd3;
      tick();
      reset    = 1'b0;
      MnDStart = 1'b0;
      MnDWe    = 1'b0;
      checks++; if (MnDBusy !== 1'b0) begin errors++; $display("FAIL reset_prio_busy: got %b expected 0", MnDBusy); end
      checks++; if (LO !== 32'd0 || HI !== 32'd0) begin errors++; $display("FAIL reset_prio_hilo: got %h_%h expected 00000000_00000000", HI, LO); end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_multu();
      test_div();
      test_div_signs();
      test_mthi_mtlo();
      test_start_priority();
      test_reset_mid_op();
      test_back_to_back();
      test_reset_priority();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
